// File: rtl/audio_gain.sv
// Volume stage for the FM audio chain: scales each sample by an
// unsigned fixed-point gain, floors, saturates; 3-stage FIFO-to-FIFO pipe.
module audio_gain #(
    parameter int DATA_WIDTH = 32,
    parameter int VOL_WIDTH  = 16,
    parameter int FRAC_BITS  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [VOL_WIDTH-1:0]  volume,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic                  x_in_rd_en,
    input  logic                  x_in_empty,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_out_wr_en,
    input  logic                  y_out_full
);

    localparam int PW = DATA_WIDTH + VOL_WIDTH + 1;

    logic                         advance;
    logic                         v1;
    logic                         v2;
    logic                         v3;
    logic [DATA_WIDTH-1:0]        x1;
    logic [VOL_WIDTH-1:0]         vol1;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         x_ext;
    logic signed [PW-1:0]         vol_ext;
    logic signed [PW-1:0]         prod_next;
    logic signed [PW-1:0]         shifted;
    logic [PW-DATA_WIDTH:0]       hi;
    logic [DATA_WIDTH-1:0]        sat;

    assign advance     = ~v3 | ~y_out_full;
    assign x_in_rd_en  = advance & ~x_in_empty & ~reset;
    assign y_out_wr_en = v3 & ~y_out_full & ~reset;

    always_comb begin
        x_ext     = {{(PW-DATA_WIDTH){x1[DATA_WIDTH-1]}}, x1};
        vol_ext   = {{(PW-VOL_WIDTH){1'b0}}, vol1};
        prod_next = x_ext * vol_ext;
    end

    // In range only if every bit above the output sign bit matches it.
    always_comb begin
        shifted = prod >>> FRAC_BITS;
        hi      = shifted[PW-1:DATA_WIDTH-1];
        if ((&hi) || ~(|hi)) begin
            sat = shifted[DATA_WIDTH-1:0];
        end else if (shifted[PW-1]) begin
            sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            x1    <= '0;
            vol1  <= '0;
            prod  <= '0;
            y_out <= '0;
        end else if (advance) begin
            v1    <= x_in_rd_en;
            x1    <= x_in;
            vol1  <= volume;
            v2    <= v1;
            prod  <= prod_next;
            v3    <= v2;
            y_out <= sat;
        end
    end

endmodule

// File: tb/tb_audio_gain.sv
// Bench for audio_gain: FIFO-modelled source, scoreboard of expected
// outputs, table vectors plus stall, volume-step and reset sequences.
module tb_audio_gain;

    typedef struct {
        logic [31:0] x;
        logic [15:0] vol;
        logic [31:0] exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic [15:0] volume;
    logic [31:0] x_in;
    logic        x_in_rd_en;
    logic        x_in_empty;
    logic [31:0] y_out;
    logic        y_out_wr_en;
    logic        y_out_full;

    audio_gain dut (
        .clock       (clock),
        .reset       (reset),
        .volume      (volume),
        .x_in        (x_in),
        .x_in_rd_en  (x_in_rd_en),
        .x_in_empty  (x_in_empty),
        .y_out       (y_out),
        .y_out_wr_en (y_out_wr_en),
        .y_out_full  (y_out_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    vec_t        src[$];
    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pops = 0;
    int          pushes = 0;
    int          first_pop = -1;
    int          first_push = -1;
    bit          hold_empty = 0;
    bit          force_full = 0;
    bit          expect_no_pop = 0;
    bit          expect_both = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(logic [31:0] x, logic [15:0] v);
        longint p;
        p = longint'($signed(x)) * longint'(v);
        p = p >>> 10;
        if (p > 64'sd2147483647) p = 64'sd2147483647;
        if (p < -64'sd2147483648) p = -64'sd2147483648;
        return p[31:0];
    endfunction

    // One clock: drive inputs at the falling edge, check what the
    // next rising edge will act on, then wait for the next falling edge.
    task automatic tick();
        vec_t d;
        x_in       = (src.size() > 0) ? src[0].x : 32'd0;
        volume     = (src.size() > 0) ? src[0].vol : 16'd0;
        x_in_empty = (src.size() == 0) || hold_empty;
        y_out_full = force_full;
        #1;
        chk("wr_en_while_full", {63'd0, y_out_wr_en & y_out_full}, 64'd0);
        chk("rd_en_while_empty", {63'd0, x_in_rd_en & x_in_empty}, 64'd0);
        if (reset) begin
            chk("rd_en_in_reset", {63'd0, x_in_rd_en}, 64'd0);
            chk("wr_en_in_reset", {63'd0, y_out_wr_en}, 64'd0);
        end
        if (expect_no_pop)
            chk("stall_no_pop", {63'd0, x_in_rd_en}, 64'd0);
        if (expect_both)
            chk("push_and_pop", {62'd0, x_in_rd_en, y_out_wr_en}, 64'd3);
        if (y_out_wr_en) begin
            pushes++;
            if (first_push < 0) first_push = cyc;
            if (exp_q.size() == 0)
                chk("spurious_push", 64'd1, 64'd0);
            else
                chk("y_out", {32'd0, y_out}, {32'd0, exp_q.pop_front()});
        end
        if (x_in_rd_en && src.size() > 0) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
            d = src.pop_front();
            exp_q.push_back(d.exp);
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((src.size() > 0 || exp_q.size() > 0) && n < 500) begin
            tick();
            n++;
        end
        if (src.size() > 0 || exp_q.size() > 0)
            chk({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic restart_stats();
        pops = 0;
        pushes = 0;
        first_pop = -1;
        first_push = -1;
    endtask

    vec_t        vecs[11];
    vec_t        r;
    logic [31:0] y_hold;

    initial begin
        vecs[0]  = '{32'd1000,      16'd1024,  32'd1000};
        vecs[1]  = '{-32'sd1000,    16'd1024,  -32'sd1000};
        vecs[2]  = '{32'h7FFFFFFF,  16'd1024,  32'h7FFFFFFF};
        vecs[3]  = '{32'd1000,      16'd512,   32'd500};
        vecs[4]  = '{-32'sd3,       16'd512,   -32'sd2};
        vecs[5]  = '{32'd3,         16'd512,   32'd1};
        vecs[6]  = '{-32'sd5,       16'd0,     32'd0};
        vecs[7]  = '{32'h7FFF0000,  16'd4096,  32'h7FFFFFFF};
        vecs[8]  = '{32'h80000000,  16'd2048,  32'h80000000};
        vecs[9]  = '{32'hFFFFFFFF,  16'd65535, -32'sd64};
        vecs[10] = '{32'h80000000,  16'd0,     32'd0};

        reset      = 1'b1;
        volume     = 16'd1024;
        x_in       = 32'd55;
        x_in_empty = 1'b0;
        y_out_full = 1'b0;
        @(negedge clock);
        #1;
        chk("reset_rd_en", {63'd0, x_in_rd_en}, 64'd0);
        chk("reset_wr_en", {63'd0, y_out_wr_en}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        x_in_empty = 1'b1;
        #1;
        chk("reset_y_out", {32'd0, y_out}, 64'd0);
        chk("reset_no_push", {63'd0, y_out_wr_en}, 64'd0);
        @(negedge clock);

        restart_stats();
        for (int i = 0; i < 11; i++) src.push_back(vecs[i]);
        drain("table");
        chk("table_latency", 64'(first_push - first_pop), 64'd3);
        chk("table_pushes", 64'(pushes), 64'd11);

        restart_stats();
        for (int i = 0; i < 100; i++) begin
            r.x   = $urandom;
            r.vol = 16'($urandom_range(0, 4096));
            r.exp = model(r.x, r.vol);
            src.push_back(r);
        end
        for (int c = 0; c < 40; c++) begin
            force_full    = (c >= 20 && c < 25);
            expect_no_pop = force_full;
            if (c == 20) y_hold = y_out;
            if (c > 20 && c <= 25)
                chk("stall_y_hold", {32'd0, y_out}, {32'd0, y_hold});
            tick();
        end
        force_full = 0;
        expect_no_pop = 0;
        drain("stream");
        chk("stream_latency", 64'(first_push - first_pop), 64'd3);
        chk("stream_pushes", 64'(pushes), 64'd100);
        chk("stream_pops", 64'(pops), 64'd100);

        for (int i = 0; i < 10; i++) begin
            r.x   = 32'd4000;
            r.vol = (i < 5) ? 16'd1024 : 16'd256;
            r.exp = (i < 5) ? 32'd4000 : 32'd1000;
            src.push_back(r);
        end
        drain("vol_step");

        src.push_back('{32'd7, 16'd1024, 32'd7});
        force_full = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("full_held_sample", {32'd0, y_out}, 64'd7);
        src.push_back('{32'd9, 16'd2048, 32'd18});
        force_full = 0;
        expect_both = 1;
        tick();
        expect_both = 0;
        drain("simul");

        restart_stats();
        for (int i = 0; i < 6; i++) begin
            r.x   = 32'(100 * (i + 1));
            r.vol = 16'd1024;
            r.exp = r.x;
            src.push_back(r);
        end
        for (int i = 0; i < 3; i++) tick();
        chk("inflight_no_push", 64'(pushes), 64'd0);
        reset = 1'b1;
        tick();
        exp_q.delete();
        reset = 1'b0;
        chk("post_reset_y_out", {32'd0, y_out}, 64'd0);
        restart_stats();
        drain("after_reset");
        chk("reset_latency", 64'(first_push - first_pop), 64'd3);
        chk("reset_pushes", 64'(pushes), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/audio_gain.md
Name: audio_gain

Overview:
- Volume/gain stage directly downstream of the de-emphasis IIR in the FM audio chain.
- Pops signed samples from the IIR output FIFO, multiplies each by a runtime unsigned fixed-point volume, arithmetic-shifts by FRAC_BITS, saturates to DATA_WIDTH and pushes the result into the audio output FIFO.
- Fully pipelined: 1 sample/cycle throughput, backpressure honoured, no sample loss or reordering.

Parameters:
- DATA_WIDTH, 32, signed two's-complement sample width for input and output.
- VOL_WIDTH, 16, width of the unsigned volume word.
- FRAC_BITS, 10, fractional bits of the volume (1024 = unity gain at default).

Ports:
- clock  in  1  single system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- volume  in  VOL_WIDTH  unsigned Q(VOL_WIDTH-FRAC_BITS).FRAC_BITS gain; sampled together with each popped sample.
- x_in  in  DATA_WIDTH  head of upstream FIFO (first-word-fall-through, valid while x_in_empty=0).
- x_in_rd_en  out  1  pop strobe to upstream FIFO.
- x_in_empty  in  1  upstream FIFO empty.
- y_out  out  DATA_WIDTH  scaled, saturated sample to downstream FIFO din.
- y_out_wr_en  out  1  push strobe to downstream FIFO.
- y_out_full  in  1  downstream FIFO full.

Behaviour:
- Three registered stages with valid bits v1..v3:
  - S1 captures x_in and volume.
  - S2 computes the product: x sign-extended by 1 bit times volume zero-extended by 1 bit, full width DATA_WIDTH+VOL_WIDTH+1 signed, no truncation.
  - S3 computes product >>> FRAC_BITS (arithmetic shift, floor rounding). If the result is > 2^(DATA_WIDTH-1)-1, it clamps to max. If it is < -2^(DATA_WIDTH-1), it clamps to min. S3 holds the final result.
- advance = ~v3 | ~y_out_full. This is the single global enable; all stages shift only when advance=1.
- Pop: x_in_rd_en = advance & ~x_in_empty (combinational). Never asserted while x_in_empty=1.
- v1 loads x_in_rd_en on advance. v2 and v3 load from the previous stage on advance. Bubbles propagate normally.
- Push: y_out_wr_en = v3 & ~y_out_full (combinational). y_out = S3 data register. Never asserted while y_out_full=1.
- Latency: a sample popped in cycle t is pushed in cycle t+3 when unstalled.
- Stall: while v3=1 and y_out_full=1, all stage registers and valids hold, no pop occurs, and y_out stays stable.
- Simultaneous full deassert and empty deassert in the same cycle: push and pop occur in that same cycle.
- Volume change mid-stream: takes effect on the first sample popped in or after the change cycle. Samples already in flight keep the volume latched with them in S1.
- volume=0 outputs 0 for every sample (including negative inputs); volume = 2^FRAC_BITS passes samples through bit-exact.
- Reset: v1..v3, all data registers and y_out go to 0. x_in_rd_en and y_out_wr_en are 0 during the reset cycle. In-flight samples are discarded. The block resumes popping on the first cycle after reset deasserts.

Test Plan:
- Unity and halving: vol=1024, x = 1000, -1000, 0x7FFFFFFF -> same values out. vol=512, x=1000 -> 500.
- Floor rounding: vol=512, x = -3 -> -2. vol=512, x = 3 -> 1. vol=0, x = -5 -> 0.
- Saturation: vol=4096, x = 0x7FFF0000 -> 0x7FFFFFFF; vol=2048, x = 0x80000000 -> 0x80000000; vol=65535, x = -1 -> -64.
- Streaming and backpressure: 100 back-to-back samples with full asserted for 5 cycles mid-stream -> 100 pushes, original order, no duplicates. wr_en never high with full, rd_en never high with empty. First push exactly 3 cycles after the first pop.
- Volume step: vol changes 1024 -> 256 between samples k and k+1 of a constant x = 4000 stream -> outputs 4000 up to sample k, then 1000 from sample k+1 onward.
- Reset mid-stream: assert reset for 1 cycle with 3 samples in flight -> no push of those samples, all outputs 0 during reset, normal operation with 3-cycle latency afterwards.
